// File: rtl/led_zone_pkg.sv
// rtl/led_zone_pkg.sv - shared zone geometry and reader FSM encoding
package led_zone_pkg;
   localparam int ZONE_COLS = 24;
   localparam int ZONE_ROWS = 15;
   localparam int ZONE_CNT  = ZONE_COLS * ZONE_ROWS;
   localparam int GRAY_W    = 8;
   localparam int ZONE_AW   = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } zone_state_e;
endpackage

// File: rtl/zone_skid_fifo.sv
// rtl/zone_skid_fifo.sv - 2-deep skid FIFO holding {gray, zone, last} in front of the serializer
module zone_skid_fifo
   import led_zone_pkg::*;
#(
   parameter int W = GRAY_W + ZONE_AW + 1
) (
   input  logic         clk_x1,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count,
   output logic         o_full,
   output logic         o_empty
);
   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_push_ok;
   logic         w_pop_ok;

   assign o_full    = (r_count == 2'd2);
   assign o_empty   = (r_count == 2'd0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   // a push into a full FIFO is only legal when the head leaves in the same cycle
   assign w_push_ok = i_push && (!o_full || i_pop);
   assign w_pop_ok  = i_pop && !o_empty;

   // storage, pointers and occupancy
   always_ff @(posedge clk_x1 or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(w_push_ok) - 2'(w_pop_ok);
      end
   end
endmodule

// File: rtl/zone_buffer_reader.sv
// rtl/zone_buffer_reader.sv - serpentine zone walker streaming gray bytes to the LED serializer; GLOBAL_DIM_EN adds global dimming
module zone_buffer_reader
   import led_zone_pkg::*;
#(
   parameter int COLS = ZONE_COLS,
   parameter int ROWS = ZONE_ROWS,
   parameter int DW   = GRAY_W,
   parameter int AW   = ZONE_AW
) (
   input  logic          clk_x1,
   input  logic          rst_n,
   input  logic          frame_start,
   output logic          rd_buf_en,
   output logic [AW-1:0] array_map,
   input  logic [DW-1:0] gray_data,
   input  logic [7:0]    dim_level,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [DW-1:0] o_gray,
   output logic [AW-1:0] o_zone,
   output logic          o_last,
   output logic          busy,
   output logic          frame_done,
   output logic          overrun
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int FW = DW + AW + 1;

   zone_state_e   r_state;
   zone_state_e   w_next;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [AW-1:0] r_row_base;
   logic          r_inflight;
   logic [AW-1:0] r_zone_d;
   logic          r_last_d;
   logic          r_frame_done;
   logic          r_overrun;
   logic          w_issue;
   logic          w_start;
   logic          w_pop;
   logic          w_col_end;
   logic          w_row_end;
   logic          w_room;
   logic [1:0]    w_count;
   logic          w_empty;
   logic          w_unused_full;
   logic [DW-1:0] w_gray_in;
   logic [FW-1:0] w_fifo_out;

`ifdef GLOBAL_DIM_EN
   logic [15:0]   w_prod;
   assign w_prod    = 16'(gray_data) * (16'(dim_level) + 16'd1);
   assign w_gray_in = DW'(w_prod >> 8);
`else
   logic          w_unused_dim;
   assign w_unused_dim = ^dim_level;
   assign w_gray_in    = gray_data;
`endif

   assign w_col_end = (r_col == CW'(COLS - 1));
   assign w_row_end = (r_row == RW'(ROWS - 1));
   assign w_pop     = !w_empty && o_ready;
   // occupancy after this cycle's pop plus the byte still returning must leave room for one more
   assign w_room    = (2'(w_count - 2'(w_pop)) + 2'(r_inflight)) < 2'd2;
   // odd rows run right-to-left so the LED chain snakes through the panel
   assign array_map = r_row[0] ? (r_row_base + AW'(COLS - 1) - AW'(r_col))
                               : (r_row_base + AW'(r_col));
   assign rd_buf_en  = w_issue;
   assign o_valid    = !w_empty;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;
   assign {o_gray, o_zone, o_last} = w_fifo_out;

   // state register
   always_ff @(posedge clk_x1 or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // next state and read issue
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_issue = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (frame_start) begin
               w_next  = ST_RUN;
               w_start = 1'b1;
            end
         end
         ST_RUN: begin
            w_issue = w_room;
            if (w_room && w_col_end && w_row_end) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_pop && o_last) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // row/column walker; row_base accumulates COLS instead of multiplying
   always_ff @(posedge clk_x1 or negedge rst_n) begin
      if (!rst_n) begin
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
      end else if (w_start) begin
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
      end else if (w_issue) begin
         if (w_col_end) begin
            r_col      <= '0;
            r_row      <= r_row + RW'(1);
            r_row_base <= r_row_base + AW'(COLS);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // tag the returning read with its address and end-of-frame marker
   always_ff @(posedge clk_x1 or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_zone_d   <= '0;
         r_last_d   <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_zone_d   <= array_map;
         r_last_d   <= w_issue && w_col_end && w_row_end;
      end
   end

   // frame_done and overrun status pulses
   always_ff @(posedge clk_x1 or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= (r_state == ST_DRAIN) && w_pop && o_last;
         r_overrun    <= frame_start && (r_state != ST_IDLE);
      end
   end

   zone_skid_fifo #(.W(FW)) u_fifo (
      .clk_x1  (clk_x1),
      .rst_n   (rst_n),
      .i_push  (r_inflight),
      .i_data  ({w_gray_in, r_zone_d, r_last_d}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_count (w_count),
      .o_full  (w_unused_full),
      .o_empty (w_empty)
   );
endmodule

// File: tb/tb_zone_buffer_reader.sv
// tb/tb_zone_buffer_reader.sv - self-checking bench for zone_buffer_reader
module tb_zone_buffer_reader;
   logic       clk_x1 = 1'b0;
   logic       rst_n;
   logic       frame_start;
   logic       rd_buf_en;
   logic [8:0] array_map;
   logic [7:0] gray_data;
   logic [7:0] dim_level;
   logic       o_valid;
   logic       o_ready;
   logic [7:0] o_gray;
   logic [8:0] o_zone;
   logic       o_last;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   typedef struct {logic [7:0] gray; logic [8:0] zone; logic last;} exp_t;
   typedef struct {int n; int rd; int addr; int valid; int zone; int last; int busy; int done;} tv_t;
   typedef struct {logic [7:0] dim; int gray;} dv_t;

   exp_t sb[$];
   tv_t  tv[14];
   dv_t  dv[3];
   int   n_chk = 0;
   int   n_fail = 0;
   int   ready_mode = 0;
   bit   gray_const = 0;
   int   occ = 0;
   int   infl = 0;
   int   xfer_cnt = 0;
   int   done_cnt = 0;
   int   ovr_cnt = 0;
   bit   prev_stall = 0;
   logic [17:0] prev_word;

   zone_buffer_reader dut (
      .clk_x1(clk_x1), .rst_n(rst_n), .frame_start(frame_start),
      .rd_buf_en(rd_buf_en), .array_map(array_map), .gray_data(gray_data),
      .dim_level(dim_level), .o_valid(o_valid), .o_ready(o_ready),
      .o_gray(o_gray), .o_zone(o_zone), .o_last(o_last), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk_x1 = ~clk_x1;

   // buffer model: one-cycle read latency, junk when not being read
   always @(posedge clk_x1)
      gray_data <= rd_buf_en ? (gray_const ? 8'd200 : array_map[7:0]) : 8'($urandom);

   task automatic chk_eq(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int g);
      for (int k = 0; k < 360; k++) begin
         exp_t e;
         int row, col, z;
         row = k / 24;
         col = k % 24;
         z = (row % 2 == 0) ? row * 24 + col : row * 24 + 23 - col;
         e.zone = 9'(z);
         e.gray = (g < 0) ? 8'(z) : 8'(g);
         e.last = (k == 359);
         sb.push_back(e);
      end
   endtask

   task automatic pulse_start(input bit accept, input int g);
      @(posedge clk_x1); #1;
      frame_start = 1'b1;
      if (accept) push_frame(g);
      @(posedge clk_x1); #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_x1);
         if (frame_done) begin
            seen = 1;
            break;
         end
      end
      chk_eq("frame_done_seen", int'(seen), 1);
   endtask

   // downstream ready driver
   initial begin
      o_ready = 1'b0;
      forever begin
         @(posedge clk_x1); #1;
         case (ready_mode)
            0:       o_ready = 1'b0;
            1:       o_ready = 1'b1;
            default: o_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // output monitor: scoreboard, hold-stability and read-credit checks
   always @(negedge clk_x1) begin
      if (!rst_n) begin
         occ = 0;
         infl = 0;
         prev_stall = 0;
         sb.delete();
      end else begin
         int xfer;
         xfer = (o_valid && o_ready) ? 1 : 0;
         chk_eq("valid_vs_occupancy", int'(o_valid), int'(occ != 0));
         if (prev_stall) begin
            chk_eq("hold_valid", int'(o_valid), 1);
            chk_eq("hold_data", int'({o_gray, o_zone, o_last}), int'(prev_word));
         end
         if (rd_buf_en) chk_eq("rd_credit", int'(occ - xfer + infl < 2), 1);
         if (xfer == 1) begin
            if (sb.size() == 0) begin
               chk_eq("unexpected_byte_zone", int'(o_zone), -1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk_eq("byte_gray", int'(o_gray), int'(e.gray));
               chk_eq("byte_zone", int'(o_zone), int'(e.zone));
               chk_eq("byte_last", int'(o_last), int'(e.last));
            end
            xfer_cnt++;
         end
         occ = occ + infl - xfer;
         chk_eq("occupancy_le_2", int'(occ <= 2), 1);
         infl = rd_buf_en ? 1 : 0;
         prev_stall = o_valid && !o_ready;
         prev_word = {o_gray, o_zone, o_last};
         if (frame_done) done_cnt++;
         if (overrun) ovr_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      //            n    rd addr val zone last busy done
      tv[0]  = '{  0,   1,   0,  0,  -1,  -1,  1,  0};
      tv[1]  = '{  1,   1,   1,  0,  -1,  -1,  1,  0};
      tv[2]  = '{  2,   1,   2,  1,   0,   0,  1,  0};
      tv[3]  = '{  3,   1,   3,  1,   1,   0,  1,  0};
      tv[4]  = '{ 23,   1,  23,  1,  21,   0,  1,  0};
      tv[5]  = '{ 24,   1,  47,  1,  22,   0,  1,  0};
      tv[6]  = '{ 25,   1,  46,  1,  23,   0,  1,  0};
      tv[7]  = '{ 26,   1,  45,  1,  47,   0,  1,  0};
      tv[8]  = '{ 47,   1,  24,  1,  26,   0,  1,  0};
      tv[9]  = '{359,   1, 359,  1, 357,   0,  1,  0};
      tv[10] = '{360,   0,  -1,  1, 358,   0,  1,  0};
      tv[11] = '{361,   0,  -1,  1, 359,   1,  1,  0};
      tv[12] = '{362,   0,  -1,  0,  -1,  -1,  0,  1};
      tv[13] = '{363,   0,  -1,  0,  -1,  -1,  0,  0};
`ifdef GLOBAL_DIM_EN
      dv[0] = '{8'd255, 200};
      dv[1] = '{8'd127, 100};
      dv[2] = '{8'd0,   0};
`else
      dv[0] = '{8'd0,   200};
      dv[1] = '{8'd127, 200};
      dv[2] = '{8'd255, 200};
`endif

      rst_n = 1'b0;
      frame_start = 1'b0;
      dim_level = 8'd255;
      repeat (3) @(negedge clk_x1);
      chk_eq("rst_rd_buf_en", int'(rd_buf_en), 0);
      chk_eq("rst_o_valid", int'(o_valid), 0);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_frame_done", int'(frame_done), 0);
      chk_eq("rst_overrun", int'(overrun), 0);
      chk_eq("rst_array_map", int'(array_map), 0);
      rst_n = 1'b1;

      // timing table and serpentine order with o_ready held high
      ready_mode = 1;
      repeat (2) @(negedge clk_x1);
      base = done_cnt;
      pulse_start(1, -1);
      begin
         int idx = 0;
         for (int c = 0; c <= 363; c++) begin
            @(negedge clk_x1);
            while (idx < 14 && tv[idx].n == c) begin
               chk_eq("t_rd_buf_en", int'(rd_buf_en), tv[idx].rd);
               if (tv[idx].addr >= 0) chk_eq("t_array_map", int'(array_map), tv[idx].addr);
               chk_eq("t_o_valid", int'(o_valid), tv[idx].valid);
               if (tv[idx].zone >= 0) chk_eq("t_o_zone", int'(o_zone), tv[idx].zone);
               if (tv[idx].last >= 0) chk_eq("t_o_last", int'(o_last), tv[idx].last);
               chk_eq("t_busy", int'(busy), tv[idx].busy);
               chk_eq("t_frame_done", int'(frame_done), tv[idx].done);
               idx++;
            end
         end
      end
      chk_eq("t1_queue_empty", sb.size(), 0);
      chk_eq("t1_done_count", done_cnt - base, 1);

      // random backpressure
      ready_mode = 2;
      base = done_cnt;
      pulse_start(1, -1);
      wait_done(3000);
      chk_eq("t2_queue_empty", sb.size(), 0);
      @(negedge clk_x1);
      chk_eq("t2_done_count", done_cnt - base, 1);

      // overrun mid-frame, then back-to-back frame on the frame_done cycle
      ready_mode = 1;
      base = done_cnt;
      pulse_start(1, -1);
      repeat (100) @(negedge clk_x1);
      pulse_start(0, 0);
      @(negedge clk_x1);
      chk_eq("t3_overrun_pulse", int'(overrun), 1);
      @(negedge clk_x1);
      chk_eq("t3_overrun_clear", int'(overrun), 0);
      chk_eq("t3_busy_kept", int'(busy), 1);
      wait_done(1000);
      chk_eq("t3_queue_empty", sb.size(), 0);
      frame_start = 1'b1;
      push_frame(-1);
      @(posedge clk_x1); #1;
      frame_start = 1'b0;
      @(negedge clk_x1);
      chk_eq("t3_b2b_busy", int'(busy), 1);
      chk_eq("t3_b2b_no_overrun", int'(overrun), 0);
      wait_done(1000);
      chk_eq("t3_b2b_queue_empty", sb.size(), 0);
      @(negedge clk_x1);
      chk_eq("t3_done_count", done_cnt - base, 2);
      chk_eq("t3_overrun_count", ovr_cnt, 1);

      // reset mid-frame with the output stalled
      base = done_cnt;
      xfer_cnt = 0;
      pulse_start(1, -1);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_x1);
         if (xfer_cnt >= 150) break;
      end
      chk_eq("t4_reached_150", int'(xfer_cnt >= 150), 1);
      ready_mode = 0;
      repeat (3) @(posedge clk_x1);
      #1 rst_n = 1'b0;
      @(negedge clk_x1);
      chk_eq("t4_rd_buf_en", int'(rd_buf_en), 0);
      chk_eq("t4_array_map", int'(array_map), 0);
      chk_eq("t4_o_valid", int'(o_valid), 0);
      chk_eq("t4_o_gray", int'(o_gray), 0);
      chk_eq("t4_o_zone", int'(o_zone), 0);
      chk_eq("t4_o_last", int'(o_last), 0);
      chk_eq("t4_busy", int'(busy), 0);
      chk_eq("t4_frame_done", int'(frame_done), 0);
      chk_eq("t4_overrun", int'(overrun), 0);
      @(negedge clk_x1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_x1);
      chk_eq("t4_no_done", done_cnt - base, 0);
      ready_mode = 1;
      pulse_start(1, -1);
      wait_done(1000);
      chk_eq("t4_queue_empty", sb.size(), 0);

      // dimming table
      gray_const = 1;
      for (int i = 0; i < 3; i++) begin
         dim_level = dv[i].dim;
         pulse_start(1, dv[i].gray);
         wait_done(1000);
         chk_eq("t5_queue_empty", sb.size(), 0);
      end
      gray_const = 0;

      repeat (3) @(negedge clk_x1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
